// File: rtl/demux16_pkg.sv
// Shared widths and state encoding for the 1-to-16 serial deserializer.
package demux16_pkg;
  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {S_FILL, S_FULL} state_t;
endpackage

// File: rtl/demux1to16_deserializer.sv
// Rebuilds 16-bit words from a 1-bit valid/ready stream, with one output word
// of buffering plus a second complete word that can be parked in the accumulator.
module demux1to16_deserializer
  import demux16_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  bit_idx
);

  // Handshakes: a beat moves when in_valid && in_ready, a word moves when
  // out_valid && out_ready; in_ready is a pure function of registered state.
  state_t              state;
  logic [WORD_W-1:0]   acc;
  logic [IDX_W-1:0]    cnt;
  logic [IDX_W-1:0]    pos;
  logic [WORD_W-1:0]   wr_en;
  logic [WORD_W-1:0]   acc_merged;
  logic                accept;
  logic                xfer;
  logic                slot_free;
  logic                last_beat;

  assign in_ready   = (state == S_FILL);
  assign bit_idx    = cnt;
  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign slot_free  = !out_valid || xfer;
  assign last_beat  = accept && (cnt == IDX_W'(WORD_W - 1));
  assign pos        = LSB_FIRST ? cnt : (IDX_W'(WORD_W - 1) - cnt);
  assign acc_merged = in_bit ? (acc | wr_en) : (acc & ~wr_en);

  always_comb begin
    wr_en = '0;
    case (pos)
      4'd0:    wr_en = 16'h0001;
      4'd1:    wr_en = 16'h0002;
      4'd2:    wr_en = 16'h0004;
      4'd3:    wr_en = 16'h0008;
      4'd4:    wr_en = 16'h0010;
      4'd5:    wr_en = 16'h0020;
      4'd6:    wr_en = 16'h0040;
      4'd7:    wr_en = 16'h0080;
      4'd8:    wr_en = 16'h0100;
      4'd9:    wr_en = 16'h0200;
      4'd10:   wr_en = 16'h0400;
      4'd11:   wr_en = 16'h0800;
      4'd12:   wr_en = 16'h1000;
      4'd13:   wr_en = 16'h2000;
      4'd14:   wr_en = 16'h4000;
      4'd15:   wr_en = 16'h8000;
      default: wr_en = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FILL;
      acc       <= '0;
      cnt       <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= S_FILL;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      // A load later in this block overrides the clear on the same edge.
      if (xfer) out_valid <= 1'b0;
      case (state)
        S_FILL: begin
          if (accept) begin
            cnt <= cnt + 4'd1;
            if (last_beat) begin
              if (slot_free) begin
                out_word  <= acc_merged;
                out_valid <= 1'b1;
                acc       <= '0;
              end else begin
                acc   <= acc_merged;
                state <= S_FULL;
              end
            end else begin
              acc <= acc_merged;
            end
          end
        end
        S_FULL: begin
          if (xfer) begin
            out_word  <= acc;
            out_valid <= 1'b1;
            acc       <= '0;
            state     <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_demux1to16_deserializer.sv
// Directed bench for the 1-to-16 deserializer: LSB-first and MSB-first instances.
module tb_demux1to16_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  bit_idx;

  logic        m_flush;
  logic        m_in_bit;
  logic        m_in_valid;
  logic        m_in_ready;
  logic [15:0] m_out_word;
  logic        m_out_valid;
  logic        m_out_ready;
  logic [3:0]  m_bit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux1to16_deserializer #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_word(out_word), .out_valid(out_valid),
    .out_ready(out_ready), .bit_idx(bit_idx)
  );

  demux1to16_deserializer #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .flush(m_flush), .in_bit(m_in_bit), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .out_word(m_out_word), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .bit_idx(m_bit_idx)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) beat(w[i]);
    in_valid = 1'b0;
  endtask

  task automatic m_beat(input logic b);
    m_in_valid = 1'b1;
    m_in_bit   = b;
    tick();
  endtask

  initial begin
    logic [15:0] w;
    logic [31:0] stream;
    int          pulses;
    int          drops;
    int          first;

    rst = 1'b1; flush = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_flush = 1'b0; m_in_bit = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b1;
    w = '0; stream = '0; pulses = 0; drops = 0; first = 0;

    // Reset state
    tick(); tick();
    check("rst_out_word", out_word, 16'h0000);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_bit_idx", 16'(bit_idx), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_msb_word", m_out_word, 16'h0000);
    rst = 1'b0;

    // Reset mid-word, then A5C3 LSB-first
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) beat(1'b1);
    in_valid = 1'b0;
    check("mid_bit_idx7", 16'(bit_idx), 16'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_bit_idx", 16'(bit_idx), 16'd0);
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    check("mid_rst_no_accept", 16'(bit_idx), 16'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    w = 16'hA5C3;
    for (int i = 0; i < 15; i++) beat(w[i]);
    check("a5c3_valid_early", 16'(out_valid), 16'd0);
    check("a5c3_bit_idx15", 16'(bit_idx), 16'd15);
    beat(w[15]);
    in_valid = 1'b0;
    check("a5c3_valid", 16'(out_valid), 16'd1);
    check("a5c3_word", out_word, 16'hA5C3);
    check("a5c3_bit_idx0", 16'(bit_idx), 16'd0);
    tick();
    check("a5c3_pulse_end", 16'(out_valid), 16'd0);

    // Back-to-back 1234 then FFFF with out_ready high
    stream = {16'hFFFF, 16'h1234};
    for (int i = 0; i < 32; i++) begin
      beat(stream[i]);
      if (!in_ready) drops++;
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin
          first = i;
          check("b2b_word1", out_word, 16'h1234);
          check("b2b_latency", 16'(i), 16'd15);
        end else begin
          check("b2b_word2", out_word, 16'hFFFF);
          check("b2b_gap", 16'(i - first), 16'd16);
        end
      end
    end
    in_valid = 1'b0;
    check("b2b_pulses", 16'(pulses), 16'd2);
    check("b2b_in_ready_drops", 16'(drops), 16'd0);
    tick();
    check("b2b_drained", 16'(out_valid), 16'd0);

    // Backpressure: two words buffered, then one-cycle release
    out_ready = 1'b0;
    send_word(16'h00FF);
    check("bp_valid1", 16'(out_valid), 16'd1);
    check("bp_word1", out_word, 16'h00FF);
    check("bp_ready1", 16'(in_ready), 16'd1);
    send_word(16'h8001);
    check("bp_full_ready", 16'(in_ready), 16'd0);
    check("bp_full_word", out_word, 16'h00FF);
    check("bp_full_bit_idx", 16'(bit_idx), 16'd0);
    tick(); tick();
    check("bp_hold_word", out_word, 16'h00FF);
    check("bp_hold_ready", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_word", out_word, 16'h8001);
    check("bp_rel_valid", 16'(out_valid), 16'd1);
    check("bp_rel_ready", 16'(in_ready), 16'd1);
    out_ready = 1'b1;
    tick();
    check("bp_drained", 16'(out_valid), 16'd0);
    out_ready = 1'b0;

    // Transfer in the same cycle as the 16th beat
    send_word(16'h3C3C);
    check("sim_pending_word", out_word, 16'h3C3C);
    w = 16'h0F0F;
    for (int i = 0; i < 15; i++) beat(w[i]);
    check("sim_pre_valid", 16'(out_valid), 16'd1);
    check("sim_pre_word", out_word, 16'h3C3C);
    out_ready = 1'b1;
    beat(w[15]);
    in_valid = 1'b0;
    check("sim_word", out_word, 16'h0F0F);
    check("sim_valid", 16'(out_valid), 16'd1);
    check("sim_no_full", 16'(in_ready), 16'd1);
    tick();
    check("sim_drained", 16'(out_valid), 16'd0);
    out_ready = 1'b0;

    // Flush with a pending word and a concurrent beat
    send_word(16'h1357);
    check("fl_pending", 16'(out_valid), 16'd1);
    for (int i = 0; i < 5; i++) beat(1'b1);
    in_valid = 1'b0;
    check("fl_bit_idx5", 16'(bit_idx), 16'd5);
    flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_bit_idx", 16'(bit_idx), 16'd0);
    check("fl_valid", 16'(out_valid), 16'd0);
    check("fl_word_kept", out_word, 16'h1357);
    check("fl_ready", 16'(in_ready), 16'd1);
    out_ready = 1'b1;
    send_word(16'hBEEF);
    check("fl_beef_word", out_word, 16'hBEEF);
    check("fl_beef_valid", 16'(out_valid), 16'd1);
    tick();
    out_ready = 1'b0;

    // MSB-first instance: 1 then fifteen 0s, then 5A3C high bit first
    m_beat(1'b1);
    check("msb_bit_idx1", 16'(m_bit_idx), 16'd1);
    for (int i = 0; i < 15; i++) m_beat(1'b0);
    m_in_valid = 1'b0;
    check("msb_word_8000", m_out_word, 16'h8000);
    check("msb_valid", 16'(m_out_valid), 16'd1);
    w = 16'h5A3C;
    for (int i = 0; i < 16; i++) m_beat(w[15 - i]);
    m_in_valid = 1'b0;
    check("msb_word_5a3c", m_out_word, 16'h5A3C);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
